// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage enables and flushes for load-use,
// branch squash and data-memory waits with timeout; counts stall cycles.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             mem_err,
  output logic             mem_err_sticky,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       freeze;
  logic       timeout;

  always_comb begin
    load_use = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (ex_rd == id_rs1)) ||
                (id_use_rs2 && (ex_rd == id_rs2)));
    timeout  = (state == MEM_WAIT) && !mem_ready && (wait_cnt >= TMO);
    freeze   = !mem_ready &&
               (((state == RUN) && mem_req) ||
                ((state == MEM_WAIT) && (wait_cnt < TMO)));
  end

  // Memory stall outranks branch, branch squashes any load-use in ID.
  always_comb begin
    en_pc        = 1'b0;
    en_if_id     = 1'b0;
    en_id_ex     = 1'b0;
    en_ex_mem    = 1'b0;
    en_mem_wb    = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    mem_err      = 1'b0;
    if (rst) begin
      priority case (1'b1)
        timeout: begin
          mem_err      = 1'b1;
          en_id_ex     = 1'b1;
          en_ex_mem    = 1'b1;
          en_mem_wb    = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end
        freeze: begin
        end
        ex_branch_taken: begin
          en_pc       = 1'b1;
          en_if_id    = 1'b1;
          en_id_ex    = 1'b1;
          en_ex_mem   = 1'b1;
          en_mem_wb   = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
        load_use: begin
          en_id_ex    = 1'b1;
          en_ex_mem   = 1'b1;
          en_mem_wb   = 1'b1;
          flush_id_ex = 1'b1;
        end
        default: begin
          en_pc     = 1'b1;
          en_if_id  = 1'b1;
          en_id_ex  = 1'b1;
          en_ex_mem = 1'b1;
          en_mem_wb = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RUN;
      wait_cnt       <= 8'd0;
      stall_cycles   <= '0;
      mem_err_sticky <= 1'b0;
    end else begin
      if (!en_pc && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (timeout) begin
        mem_err_sticky <= 1'b1;
        state          <= RUN;
        wait_cnt       <= 8'd0;
      end else if ((state == MEM_WAIT) && mem_ready) begin
        state    <= RUN;
        wait_cnt <= 8'd0;
      end else if (freeze) begin
        state    <= MEM_WAIT;
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random
// stimulus against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int T = 4;
  localparam int W = 4;

  localparam logic [8:0] V_FRZ = 9'b000000000;
  localparam logic [8:0] V_RUN = 9'b111110000;
  localparam logic [8:0] V_BR  = 9'b111111100;
  localparam logic [8:0] V_LU  = 9'b001110100;
  localparam logic [8:0] V_TMO = 9'b001110111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0;
  logic ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic mem_err, mem_err_sticky;
  logic [W-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  bit m_wait = 0;
  int m_n = 0;
  int m_stall = 0;
  bit m_sticky = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
    .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem),
    .mem_err(mem_err), .mem_err_sticky(mem_err_sticky),
    .stall_cycles(stall_cycles)
  );

  function automatic logic [8:0] outs();
    return {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
            flush_if_id, flush_id_ex, flush_ex_mem, mem_err};
  endfunction

  function automatic logic [8:0] model_v();
    bit lu;
    if (!rst) return V_FRZ;
    if (m_wait && !mem_ready) return (m_n < T) ? V_FRZ : V_TMO;
    if (!m_wait && mem_req && !mem_ready) return V_FRZ;
    if (ex_branch_taken) return V_BR;
    lu = ex_mem_read && ex_rd != 0 &&
         ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    return lu ? V_LU : V_RUN;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_n = 0; m_stall = 0; m_sticky = 0;
  endtask

  task automatic tick();
    logic [8:0] e;
    e = model_v();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      if (!e[8] && m_stall < (1 << W) - 1) m_stall++;
      if (e[0]) begin m_sticky = 1; m_wait = 0; m_n = 0; end
      else if (m_wait && mem_ready) begin m_wait = 0; m_n = 0; end
      else if (m_wait) m_n++;
      else if (mem_req && !mem_ready) begin m_wait = 1; m_n = 1; end
    end
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    clear_in();
    rst = 0;
    #1;
    model_reset();
    repeat (2) tick();
    rst = 1;
    #1;
  endtask

  task automatic test_reset();
    rst = 0; clear_in(); mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs() !== V_FRZ || stall_cycles !== '0) begin
        errors++;
        $display("FAIL reset_hold: outs %b cnt %0d want %b 0", outs(), stall_cycles, V_FRZ);
      end
      tick();
    end
    rst = 1; #1;
    checks++;
    if (outs() !== V_FRZ) begin
      errors++; $display("FAIL reset_first_wait: outs %b want %b", outs(), V_FRZ);
    end
    tick();
    mem_req = 0; #1;
    checks++;
    if (outs() !== V_FRZ) begin
      errors++; $display("FAIL reset_mem_wait_state: outs %b want %b", outs(), V_FRZ);
    end
    mem_ready = 1; #1;
    checks++;
    if (outs() !== V_RUN) begin
      errors++; $display("FAIL reset_release: outs %b want %b", outs(), V_RUN);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    id_rs1 = 3; id_use_rs1 = 1; #1;
    checks++;
    if (en_pc !== 0 || en_if_id !== 0 || flush_id_ex !== 1 || outs() !== model_v()) begin
      errors++; $display("FAIL load_use: outs %b want %b", outs(), V_LU);
    end
    tick();
    checks++;
    if (stall_cycles !== 4'd1) begin
      errors++; $display("FAIL load_use_count: got %0d want 1", stall_cycles);
    end
    ex_rd = 0; id_rs2 = 0; #1;
    checks++;
    if (outs() !== V_RUN) begin
      errors++; $display("FAIL load_use_x0: outs %b want %b", outs(), V_RUN);
    end
    tick();
    checks++;
    if (stall_cycles !== 4'd1) begin
      errors++; $display("FAIL load_use_x0_count: got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_branch_lu();
    do_reset();
    ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    ex_branch_taken = 1; #1;
    checks++;
    if (outs() !== V_BR) begin
      errors++; $display("FAIL branch_lu: outs %b want %b", outs(), V_BR);
    end
    tick();
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++; $display("FAIL branch_lu_count: got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1; ex_branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs() !== V_FRZ) begin
        errors++; $display("FAIL mem_wait_c%0d: outs %b want %b", i, outs(), V_FRZ);
      end
      tick();
    end
    mem_ready = 1; #1;
    checks++;
    if (outs() !== V_BR) begin
      errors++; $display("FAIL mem_release: outs %b want %b", outs(), V_BR);
    end
    tick();
    checks++;
    if (stall_cycles !== 4'd4) begin
      errors++; $display("FAIL mem_wait_count: got %0d want 4", stall_cycles);
    end
  endtask

  task automatic test_timeout(input bit late_ready);
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs() !== V_FRZ) begin
        errors++; $display("FAIL tmo_wait_c%0d: outs %b want %b", i, outs(), V_FRZ);
      end
      tick();
    end
    mem_ready = late_ready; #1;
    checks++;
    if (outs() !== (late_ready ? V_RUN : V_TMO)) begin
      errors++;
      $display("FAIL tmo_cycle ready=%0d: outs %b want %b", late_ready, outs(),
               late_ready ? V_RUN : V_TMO);
    end
    tick();
    mem_req = 0; mem_ready = 0; #1;
    checks++;
    if (mem_err_sticky !== !late_ready || mem_err !== 0 || en_pc !== 1) begin
      errors++;
      $display("FAIL tmo_after ready=%0d: sticky %b err %b en_pc %b", late_ready,
               mem_err_sticky, mem_err, en_pc);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    mem_req = 1;
    repeat (2) tick();
    #2 rst = 0;
    #1;
    model_reset();
    checks++;
    if (outs() !== V_FRZ || stall_cycles !== '0) begin
      errors++; $display("FAIL async_reset: outs %b cnt %0d want 0 0", outs(), stall_cycles);
    end
    tick();
    rst = 1; mem_req = 0; #1;
    checks++;
    if (outs() !== V_RUN) begin
      errors++; $display("FAIL async_reset_run: outs %b want %b", outs(), V_RUN);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    mem_req = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++;
      if (outs() !== model_v()) begin
        errors++; $display("FAIL sat_c%0d: outs %b want %b", i, outs(), model_v());
      end
      tick();
    end
    checks++;
    if (stall_cycles !== 4'd15) begin
      errors++; $display("FAIL saturation: got %0d want 15", stall_cycles);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_mem_read = 1'($urandom); ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_req = ($urandom_range(0, 2) == 0);
      mem_ready = ($urandom_range(0, 4) == 0);
      #1;
      if (!rst) model_reset();
      checks++;
      if (outs() !== model_v()) begin
        errors++; $display("FAIL rand_out_c%0d: outs %b want %b", i, outs(), model_v());
      end
      tick();
      checks++;
      if (stall_cycles !== W'(m_stall) || mem_err_sticky !== m_sticky) begin
        errors++;
        $display("FAIL rand_state_c%0d: cnt %0d sticky %b want %0d %b", i,
                 stall_cycles, mem_err_sticky, m_stall, m_sticky);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
